data_mem_access: RTL

- Sequences every data-memory access requested by the multicycle control unit (ld/sd and sub-word variants) against a 64-bit data memory with a req/gnt/rvalid handshake.
- Sits between control unit/datapath (address from ALU-out register, store data from register B) and the data memory.
- Produces the extended load value (acts as the MDR) and a completion pulse on which the control unit waits.

---
 rtl/riscv_pkg.sv | 47 ++++
 rtl/load_extend.sv | 27 ++
 rtl/data_mem_access.sv | 133 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory access sequencer: size codes,
// access states, load/store funct3 values and lane helpers.
package riscv_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RD,
    DONE,
    ERR
  } acc_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SD  = 3'b011;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    logic [7:0] m;
    case (sz)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
    logic bad;
    case (sz)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = |off[1:0];
      default: bad = |off;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Aligns the addressed lane of a read doubleword to bit 0 and sign- or
// zero-extends it according to the load size.
module load_extend
  import riscv_pkg::*;
(
  input  logic [2:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [63:0] mem_rdata_i,
  output logic [63:0] ext_o
);

  logic [63:0] shifted;
  logic        sx;

  always_comb begin
    shifted = mem_rdata_i >> {off_i, 3'b000};
    sx      = ~funct3_i[2];
    ext_o   = shifted;
    case (funct3_i[1:0])
      SZ_B:    ext_o = {{56{sx & shifted[7]}},  shifted[7:0]};
      SZ_H:    ext_o = {{48{sx & shifted[15]}}, shifted[15:0]};
      SZ_W:    ext_o = {{32{sx & shifted[31]}}, shifted[31:0]};
      default: ext_o = shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_access.sv
// Sequences one load/store from the multicycle control unit against a
// req/gnt/rvalid data memory and holds the extended load result (MDR).
module data_mem_access
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_be,
  output logic [63:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  acc_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  be_q, be_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] rdata_q, rdata_d;
  logic [63:0] ext;

  load_extend u_ext (
    .off_i       (addr_q[2:0]),
    .funct3_i    (funct3_q),
    .mem_rdata_i (mem_rdata),
    .ext_o       (ext)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          we_d     = we;
          funct3_d = funct3;
          addr_d   = addr;
          be_d     = size_mask(funct3[1:0]) << addr[2:0];
          if (we) wdata_d = wdata << {addr[2:0], 3'b000};
          // Rejected accesses never reach the memory.
          if (misaligned(funct3[1:0], addr[2:0]) || (we && funct3[2])) state_d = ERR;
          else                                                         state_d = REQ;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          if (we_q) begin
            state_d = DONE;
          end else if (mem_rvalid) begin
            rdata_d = ext;
            state_d = DONE;
          end else begin
            cnt_d   = '0;
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        // rvalid wins over the timeout in the limit cycle.
        if (mem_rvalid) begin
          rdata_d = ext;
          state_d = DONE;
        end else if (cnt_q == LIMIT) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE) || (state_q == ERR);
  assign err       = (state_q == ERR);
  assign rdata     = rdata_q;
  assign mem_req   = (state_q == REQ);
  assign mem_we    = we_q & mem_req;
  assign mem_addr  = {addr_q[63:3], 3'b000};
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

endmodule
